// File: rtl/alarm_sequencer.sv
// rtl/alarm_sequencer.sv - beep/burst tone sequencer for the egg-timer alarm
// Optional ESCALATE_EN: tone type rises with each burst, saturating at 4.
module alarm_sequencer #(
    parameter int TICK_DIV = 17000,
    parameter int ON_MS    = 150,
    parameter int OFF_MS   = 100,
    parameter int PAUSE_MS = 600,
    parameter int BEEPS    = 4,
    parameter int BURSTS   = 8
) (
    input  logic       pulse_17MHz,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic [3:0] tone_sel,
    output logic       audio_en,
    output logic [3:0] audioselection,
    output logic       busy,
    output logic       done
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        BEEP_ON  = 3'd1,
        BEEP_OFF = 3'd2,
        PAUSE    = 3'd3,
        DONE     = 3'd4
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [PW-1:0]   presc;
    logic [15:0]     ms_cnt;
    logic [7:0]      beep_cnt;
    logic [7:0]      burst_cnt;
    logic [3:0]      tone_lat;

    logic [7:0]      beep_n;
    logic [7:0]      burst_n;
    logic [3:0]      tone_n;
    logic [3:0]      sel_n;
    logic [15:0]     ms_lim;
    logic            tick;
    logic            phase_end;
    logic            last_burst;
    logic            entering;
    logic            busy_n;
    logic            counting;

    assign tick       = (presc == PW'(TICK_DIV - 1));
    assign last_burst = (BURSTS != 0) && (burst_cnt == 8'(BURSTS - 1));

    always_comb begin
        ms_lim = 16'd0;
        case (state)
            BEEP_ON:  ms_lim = 16'(ON_MS - 1);
            BEEP_OFF: ms_lim = 16'(OFF_MS - 1);
            PAUSE:    ms_lim = 16'(PAUSE_MS - 1);
            default:  ms_lim = 16'd0;
        endcase
    end

    assign phase_end = tick && (ms_cnt == ms_lim);

    always_comb begin
        state_n = state;
        beep_n  = beep_cnt;
        burst_n = burst_cnt;
        tone_n  = tone_lat;
        if (stop) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state_n = BEEP_ON;
                        tone_n  = tone_sel;
                        beep_n  = 8'd0;
                        burst_n = 8'd0;
                    end
                end
                BEEP_ON: begin
                    if (phase_end) begin
                        if (beep_cnt < 8'(BEEPS - 1))
                            state_n = BEEP_OFF;
                        else if (last_burst)
                            state_n = DONE;
                        else
                            state_n = PAUSE;
                    end
                end
                BEEP_OFF: begin
                    if (phase_end) begin
                        state_n = BEEP_ON;
                        beep_n  = beep_cnt + 8'd1;
                    end
                end
                PAUSE: begin
                    if (phase_end) begin
                        state_n = BEEP_ON;
                        beep_n  = 8'd0;
                        burst_n = (burst_cnt == 8'hFF) ? 8'hFF : burst_cnt + 8'd1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign entering = (state_n != state);
    assign busy_n   = (state_n == BEEP_ON) || (state_n == BEEP_OFF) || (state_n == PAUSE);
    assign counting = busy_n && !entering;

`ifdef ESCALATE_EN
    logic [8:0] sel_sum;
    always_comb begin
        sel_sum = {5'd0, tone_n} + {1'b0, burst_n};
        if (tone_n > 4'd4)
            sel_n = tone_n;
        else if (sel_sum > 9'd4)
            sel_n = 4'd4;
        else
            sel_n = sel_sum[3:0];
    end
`else
    assign sel_n = tone_n;
`endif

    always_ff @(posedge pulse_17MHz) begin
        if (reset) begin
            state          <= IDLE;
            presc          <= '0;
            ms_cnt         <= 16'd0;
            beep_cnt       <= 8'd0;
            burst_cnt      <= 8'd0;
            tone_lat       <= 4'd0;
            audio_en       <= 1'b0;
            audioselection <= 4'd0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            state     <= state_n;
            beep_cnt  <= beep_n;
            burst_cnt <= burst_n;
            tone_lat  <= tone_n;
            // Time base restarts on every phase entry so phase length is exact.
            if (!counting) begin
                presc  <= '0;
                ms_cnt <= 16'd0;
            end else if (tick) begin
                presc  <= '0;
                ms_cnt <= ms_cnt + 16'd1;
            end else begin
                presc  <= presc + PW'(1);
            end
            audio_en <= (state_n == BEEP_ON);
            busy     <= busy_n;
            done     <= (state_n == DONE);
            if (busy_n)
                audioselection <= sel_n;
        end
    end

endmodule
